// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the Ethernet store-and-forward packet FIFO.
package eth_pkt_pkg;

  // Default width of the packet / drop / error statistics counters.
  localparam int unsigned CNT_W_DEF = 16;

  // Ingress write-side framing states.
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } wr_state_e;

endpackage

// File: rtl/eth_pkt_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered, resettable read-data output that holds when not read.
module eth_pkt_ram #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; this register doubles as the egress output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet FIFO: commits only complete, well-framed packets,
// drops overflowing/oversize packets whole, and presents a ready/valid egress.
module eth_pkt_fifo
  import eth_pkt_pkg::*;
#(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned MAX_PKT_WORDS = 32,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     inSop,
  input  logic                     inEop,
  input  logic                     vld,
  output logic [DATA_W-1:0]        outData,
  output logic                     outSop,
  output logic                     outEop,
  output logic                     outvld,
  input  logic                     outRdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pktCount,
  output logic [CNT_W-1:0]         dropCount,
  output logic [CNT_W-1:0]         errCount
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LEN_W = $clog2(MAX_PKT_WORDS + 1);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } pkt_word_t;

  wr_state_e        state, state_nxt;
  logic [PW-1:0]    wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic [PW-1:0]    wr_ptr_nxt, commit_ptr_nxt;
  logic [PW-1:0]    wr_used, commit_used;
  logic [LEN_W-1:0] len, len_nxt;
  logic             start_full, body_full;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             pkt_inc, drop_inc, err_inc;
  logic             rd_en, xfer;
  pkt_word_t        wr_word, rd_word;

  // rd_ptr advances on egress transfer, so the word sitting in the output
  // register still occupies its slot; fetch_ptr tracks what has been read
  // out of the RAM into that register.
  assign wr_used     = wr_ptr - rd_ptr;
  assign commit_used = commit_ptr - rd_ptr;
  assign level       = commit_used;

  // A new packet always starts at commit_ptr (an abort rewinds to it), so the
  // start-of-packet space check is made against commit_ptr.
  assign start_full = (commit_used == PW'(DEPTH));
  assign body_full  = (wr_used == PW'(DEPTH)) || (len == LEN_W'(MAX_PKT_WORDS));

  assign wr_word = '{sop: inSop, eop: inEop, data: inData};

  assign xfer  = outvld && outRdy;
  assign rd_en = (fetch_ptr != commit_ptr) && (!outvld || outRdy);

  assign outData = rd_word.data;
  assign outSop  = rd_word.sop;
  assign outEop  = rd_word.eop;

  // Write FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Write FSM next-state: any SOP restarts framing; any EOP ends it.
  always_comb begin
    state_nxt = state;
    if (vld) begin
      if (inSop) begin
        state_nxt = inEop ? IDLE : (start_full ? DROP : RECV);
      end else begin
        unique case (state)
          IDLE:    state_nxt = IDLE;
          RECV:    if (inEop) state_nxt = IDLE;
                   else if (body_full) state_nxt = DROP;
          DROP:    if (inEop) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Write FSM actions: RAM write, pointer moves and counter increments.
  always_comb begin
    wr_en          = 1'b0;
    wr_addr        = wr_ptr[AW-1:0];
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    len_nxt        = len;
    pkt_inc        = 1'b0;
    drop_inc       = 1'b0;
    err_inc        = 1'b0;
    if (vld) begin
      if (inSop) begin
        err_inc = (state == RECV);
        if (start_full) begin
          drop_inc   = 1'b1;
          wr_ptr_nxt = commit_ptr;
          len_nxt    = '0;
        end else begin
          wr_en      = 1'b1;
          wr_addr    = commit_ptr[AW-1:0];
          wr_ptr_nxt = commit_ptr + PW'(1);
          len_nxt    = LEN_W'(1);
          if (inEop) begin
            commit_ptr_nxt = commit_ptr + PW'(1);
            pkt_inc        = 1'b1;
          end
        end
      end else if (state == IDLE) begin
        err_inc = 1'b1;
      end else if (state == RECV) begin
        if (body_full) begin
          drop_inc   = 1'b1;
          wr_ptr_nxt = commit_ptr;
          len_nxt    = '0;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + PW'(1);
          len_nxt    = len + LEN_W'(1);
          if (inEop) begin
            commit_ptr_nxt = wr_ptr + PW'(1);
            pkt_inc        = 1'b1;
          end
        end
      end
    end
  end

  // Pointers, egress valid and saturating statistics counters.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      fetch_ptr  <= '0;
      len        <= '0;
      outvld     <= 1'b0;
      pktCount   <= '0;
      dropCount  <= '0;
      errCount   <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      len        <= len_nxt;
      if (xfer)  rd_ptr    <= rd_ptr + PW'(1);
      if (rd_en) fetch_ptr <= fetch_ptr + PW'(1);
      if (rd_en)       outvld <= 1'b1;
      else if (outRdy) outvld <= 1'b0;
      if (pkt_inc  && (pktCount  != '1)) pktCount  <= pktCount  + CNT_W'(1);
      if (drop_inc && (dropCount != '1)) dropCount <= dropCount + CNT_W'(1);
      if (err_inc  && (errCount  != '1)) errCount  <= errCount  + CNT_W'(1);
    end
  end

  eth_pkt_ram #(
    .WIDTH ($bits(pkt_word_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (resetN),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Directed self-checking bench for eth_pkt_fifo.
module tb_eth_pkt_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic [63:0] inData;
  logic        inSop, inEop, vld, outRdy;

  logic [63:0] d_outData;
  logic        d_outSop, d_outEop, d_outvld;
  logic [3:0]  d_level;
  logic [15:0] d_pktCount, d_dropCount, d_errCount;

  logic [63:0] m_outData;
  logic        m_outSop, m_outEop, m_outvld;
  logic [4:0]  m_level;
  logic [15:0] m_pktCount, m_dropCount, m_errCount;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [63:0] data;
    int          cyc;
  } beat_t;
  beat_t rx_q[$];

  eth_pkt_fifo #(
    .DATA_W        (64),
    .DEPTH         (8),
    .MAX_PKT_WORDS (8),
    .CNT_W         (16)
  ) u_dut (
    .clk       (clk),
    .resetN    (resetN),
    .inData    (inData),
    .inSop     (inSop),
    .inEop     (inEop),
    .vld       (vld),
    .outData   (d_outData),
    .outSop    (d_outSop),
    .outEop    (d_outEop),
    .outvld    (d_outvld),
    .outRdy    (outRdy),
    .level     (d_level),
    .pktCount  (d_pktCount),
    .dropCount (d_dropCount),
    .errCount  (d_errCount)
  );

  eth_pkt_fifo #(
    .DATA_W        (64),
    .DEPTH         (16),
    .MAX_PKT_WORDS (4),
    .CNT_W         (16)
  ) u_max (
    .clk       (clk),
    .resetN    (resetN),
    .inData    (inData),
    .inSop     (inSop),
    .inEop     (inEop),
    .vld       (vld),
    .outData   (m_outData),
    .outSop    (m_outSop),
    .outEop    (m_outEop),
    .outvld    (m_outvld),
    .outRdy    (outRdy),
    .level     (m_level),
    .pktCount  (m_pktCount),
    .dropCount (m_dropCount),
    .errCount  (m_errCount)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every egress transfer of u_dut; sampled mid-cycle, the transfer
  // itself happens at the following rising edge.
  always @(negedge clk) begin
    if (resetN && d_outvld && outRdy) rx_q.push_back('{d_outSop, d_outEop, d_outData, cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic s, input logic e);
    inData = d; inSop = s; inEop = e; vld = 1'b1;
    tick();
    vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
  endtask

  task automatic send_pkt(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) send_word(base + 64'(i), i == 0, i == n - 1);
  endtask

  task automatic wait_rx(input int n, output bit timeout);
    timeout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (rx_q.size() >= n) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic apply_reset();
    resetN = 1'b0; vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0; outRdy = 1'b0;
    tick(); tick();
    resetN = 1'b1;
    rx_q.delete();
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0; outRdy = 1'b1;
    tick(); tick();
    checks++; if (d_outvld !== 1'b0) begin errors++; $display("FAIL rst_outvld got=%b exp=0", d_outvld); end
    checks++; if (d_outData !== 64'h0) begin errors++; $display("FAIL rst_outData got=%h exp=0", d_outData); end
    checks++; if ({d_outSop, d_outEop} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop got=%b exp=00", {d_outSop, d_outEop}); end
    checks++; if (d_level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", d_level); end
    checks++; if ({d_pktCount, d_dropCount, d_errCount} !== 48'h0) begin errors++; $display("FAIL rst_counters got=%h exp=0", {d_pktCount, d_dropCount, d_errCount}); end
    checks++; if ({m_outvld, m_level, m_pktCount, m_dropCount, m_errCount} !== 54'h0) begin errors++; $display("FAIL rst_max got=%h exp=0", {m_outvld, m_level, m_pktCount, m_dropCount, m_errCount}); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single_packet();
    bit to;
    apply_reset();
    outRdy = 1'b1;
    send_pkt(64'h0A00, 3);
    checks++; if (d_level !== 4'd3) begin errors++; $display("FAIL sp_level_commit got=%0d exp=3", d_level); end
    checks++; if (d_pktCount !== 16'd1) begin errors++; $display("FAIL sp_pktCount got=%0d exp=1", d_pktCount); end
    checks++; if (d_outvld !== 1'b0) begin errors++; $display("FAIL sp_outvld_at_commit got=%b exp=0", d_outvld); end
    tick();
    checks++; if ({d_outvld, d_outSop, d_outData} !== {1'b1, 1'b1, 64'h0A00}) begin errors++; $display("FAIL sp_first_word got=%b/%b/%h exp=1/1/0a00", d_outvld, d_outSop, d_outData); end
    wait_rx(3, to);
    checks++; if (to) begin errors++; $display("FAIL sp_timeout got=%0d beats exp=3", rx_q.size()); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL sp_beats got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++; if ({rx_q[i].sop, rx_q[i].eop, rx_q[i].data} !== {i == 0, i == 2, 64'h0A00 + 64'(i)}) begin errors++; $display("FAIL sp_beat%0d got=%b%b/%h exp=%b%b/%h", i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data, i == 0, i == 2, 64'h0A00 + 64'(i)); end
      if (i > 0) begin
        checks++; if (rx_q[i].cyc !== rx_q[i-1].cyc + 1) begin errors++; $display("FAIL sp_gap%0d got=%0d exp=%0d", i, rx_q[i].cyc, rx_q[i-1].cyc + 1); end
      end
    end
    checks++; if (d_level !== 4'd0) begin errors++; $display("FAIL sp_level_drained got=%0d exp=0", d_level); end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [63:0] exp_d;
    apply_reset();
    outRdy = 1'b0;
    send_word(64'h0B00, 1'b1, 1'b1);
    send_pkt(64'h0C00, 4);
    tick(); tick();
    checks++; if (d_pktCount !== 16'd2) begin errors++; $display("FAIL b2b_pktCount got=%0d exp=2", d_pktCount); end
    checks++; if (d_errCount !== 16'd0) begin errors++; $display("FAIL b2b_errCount got=%0d exp=0", d_errCount); end
    checks++; if (d_level !== 4'd5) begin errors++; $display("FAIL b2b_level got=%0d exp=5", d_level); end
    tick(); tick(); tick();
    checks++; if ({d_outvld, d_outSop, d_outEop, d_outData} !== {3'b111, 64'h0B00}) begin errors++; $display("FAIL b2b_hold got=%b%b%b/%h exp=111/0b00", d_outvld, d_outSop, d_outEop, d_outData); end
    outRdy = 1'b1;
    wait_rx(5, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got=%0d beats exp=5", rx_q.size()); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL b2b_beats got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      exp_d = (i == 0) ? 64'h0B00 : 64'h0C00 + 64'(i - 1);
      checks++; if ({rx_q[i].sop, rx_q[i].eop, rx_q[i].data} !== {i <= 1, i == 0 || i == 4, exp_d}) begin errors++; $display("FAIL b2b_beat%0d got=%b%b/%h exp=%b%b/%h", i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data, i <= 1, i == 0 || i == 4, exp_d); end
      if (i > 0) begin
        checks++; if (rx_q[i].cyc !== rx_q[i-1].cyc + 1) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, rx_q[i].cyc, rx_q[i-1].cyc + 1); end
      end
    end
    checks++; if (d_level !== 4'd0) begin errors++; $display("FAIL b2b_level_drained got=%0d exp=0", d_level); end
  endtask

  task automatic test_overflow();
    bit to;
    apply_reset();
    outRdy = 1'b0;
    send_pkt(64'h0D00, 6);
    send_pkt(64'h0E00, 4);
    checks++; if (d_level !== 4'd6) begin errors++; $display("FAIL ovf_level got=%0d exp=6", d_level); end
    checks++; if (d_dropCount !== 16'd1) begin errors++; $display("FAIL ovf_dropCount got=%0d exp=1", d_dropCount); end
    checks++; if (d_pktCount !== 16'd1) begin errors++; $display("FAIL ovf_pktCount got=%0d exp=1", d_pktCount); end
    checks++; if (d_errCount !== 16'd0) begin errors++; $display("FAIL ovf_errCount got=%0d exp=0", d_errCount); end
    outRdy = 1'b1;
    wait_rx(6, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout got=%0d beats exp=6", rx_q.size()); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL ovf_beats got=%0d exp=6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if ({rx_q[i].sop, rx_q[i].eop, rx_q[i].data} !== {i == 0, i == 5, 64'h0D00 + 64'(i)}) begin errors++; $display("FAIL ovf_beat%0d got=%b%b/%h exp=%b%b/%h", i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data, i == 0, i == 5, 64'h0D00 + 64'(i)); end
    end
    checks++; if (d_level !== 4'd0) begin errors++; $display("FAIL ovf_level_drained got=%0d exp=0", d_level); end
  endtask

  task automatic test_oversize();
    apply_reset();
    outRdy = 1'b0;
    send_pkt(64'h0F00, 5);
    checks++; if (m_dropCount !== 16'd1) begin errors++; $display("FAIL os_dropCount got=%0d exp=1", m_dropCount); end
    checks++; if (m_level !== 5'd0) begin errors++; $display("FAIL os_level got=%0d exp=0", m_level); end
    checks++; if (m_pktCount !== 16'd0) begin errors++; $display("FAIL os_pktCount_drop got=%0d exp=0", m_pktCount); end
    send_pkt(64'h1000, 4);
    tick();
    checks++; if (m_pktCount !== 16'd1) begin errors++; $display("FAIL os_pktCount got=%0d exp=1", m_pktCount); end
    checks++; if (m_level !== 5'd4) begin errors++; $display("FAIL os_level_commit got=%0d exp=4", m_level); end
    checks++; if ({m_outvld, m_outSop, m_outEop, m_outData} !== {3'b110, 64'h1000}) begin errors++; $display("FAIL os_head got=%b%b%b/%h exp=110/1000", m_outvld, m_outSop, m_outEop, m_outData); end
    checks++; if ({m_dropCount, m_errCount} !== {16'd1, 16'd0}) begin errors++; $display("FAIL os_counts got=%0d/%0d exp=1/0", m_dropCount, m_errCount); end
  endtask

  task automatic test_framing();
    bit to;
    apply_reset();
    outRdy = 1'b1;
    send_word(64'h2000, 1'b1, 1'b0);
    send_word(64'h2001, 1'b0, 1'b0);
    send_word(64'h2100, 1'b1, 1'b0);
    send_word(64'h2101, 1'b0, 1'b1);
    checks++; if (d_errCount !== 16'd1) begin errors++; $display("FAIL fr_errCount got=%0d exp=1", d_errCount); end
    checks++; if (d_pktCount !== 16'd1) begin errors++; $display("FAIL fr_pktCount got=%0d exp=1", d_pktCount); end
    wait_rx(2, to);
    checks++; if (to) begin errors++; $display("FAIL fr_timeout got=%0d beats exp=2", rx_q.size()); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL fr_beats got=%0d exp=2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++; if ({rx_q[i].sop, rx_q[i].eop, rx_q[i].data} !== {i == 0, i == 1, 64'h2100 + 64'(i)}) begin errors++; $display("FAIL fr_beat%0d got=%b%b/%h exp=%b%b/%h", i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data, i == 0, i == 1, 64'h2100 + 64'(i)); end
    end
    send_word(64'h2200, 1'b0, 1'b0);
    checks++; if (d_errCount !== 16'd2) begin errors++; $display("FAIL fr_stray_errCount got=%0d exp=2", d_errCount); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL fr_stray_beats got=%0d exp=2", rx_q.size()); end
    checks++; if ({d_level, d_dropCount} !== {4'd0, 16'd0}) begin errors++; $display("FAIL fr_level_drop got=%0d/%0d exp=0/0", d_level, d_dropCount); end
  endtask

  task automatic test_async_reset();
    bit to;
    apply_reset();
    outRdy = 1'b0;
    send_pkt(64'h3000, 2);
    send_word(64'h3100, 1'b1, 1'b0);
    send_word(64'h3101, 1'b0, 1'b0);
    checks++; if ({d_level, d_outvld} !== {4'd2, 1'b1}) begin errors++; $display("FAIL ar_pre got=%0d/%b exp=2/1", d_level, d_outvld); end
    resetN = 1'b0;
    #2;
    checks++; if ({d_outvld, d_outSop, d_outEop} !== 3'b000) begin errors++; $display("FAIL ar_flags got=%b exp=000", {d_outvld, d_outSop, d_outEop}); end
    checks++; if (d_outData !== 64'h0) begin errors++; $display("FAIL ar_outData got=%h exp=0", d_outData); end
    checks++; if (d_level !== 4'd0) begin errors++; $display("FAIL ar_level got=%0d exp=0", d_level); end
    checks++; if ({d_pktCount, d_dropCount, d_errCount} !== 48'h0) begin errors++; $display("FAIL ar_counters got=%h exp=0", {d_pktCount, d_dropCount, d_errCount}); end
    tick(); tick();
    resetN = 1'b1;
    rx_q.delete();
    outRdy = 1'b1;
    tick();
    send_pkt(64'h3200, 2);
    wait_rx(2, to);
    checks++; if (to) begin errors++; $display("FAIL ar_timeout got=%0d beats exp=2", rx_q.size()); end
    tick(); tick(); tick();
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL ar_beats got=%0d exp=2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++; if ({rx_q[i].sop, rx_q[i].eop, rx_q[i].data} !== {i == 0, i == 1, 64'h3200 + 64'(i)}) begin errors++; $display("FAIL ar_beat%0d got=%b%b/%h exp=%b%b/%h", i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data, i == 0, i == 1, 64'h3200 + 64'(i)); end
    end
    checks++; if ({d_pktCount, d_errCount, d_level} !== {16'd1, 16'd0, 4'd0}) begin errors++; $display("FAIL ar_after got=%0d/%0d/%0d exp=1/0/0", d_pktCount, d_errCount, d_level); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0; outRdy = 1'b0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_overflow();
    test_oversize();
    test_framing();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
